// File: rtl/sha3_host_ctrl.sv
`timescale 1ns/1ps
// Host-side initiator for the sha3_xl register/command interface: length, 25 state words, start, digest readback.
// Latency: LEN_HOLD + 2*N_WORDS + stall cycles + 1 to START; each digest word takes 2 read cycles before m_valid.
// Backpressure: s_ready only while a stream word is awaited (core held on IDLE meanwhile); m_data/m_last hold until m_ready.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   cmd_start, cmd_len       start pulse (sampled only when idle), message length in bits
//   s_data/s_valid/s_ready   message word stream in
//   m_data/m_valid/m_ready   digest word stream out, m_last marks the final word
//   busy, done, err          not idle; one-cycle completion pulse; sticky watchdog flag
//   core_*                   sha3_xl control/add/data_in/data_out/end_op
// Optional feature: define SHA3_CTRL_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT cycles).
// Without it, WAIT blocks until end_op and err is constant 0.
module sha3_host_ctrl #(
    parameter int D_WIDTH      = 64,
    parameter int N_WORDS      = 25,
    parameter int DIGEST_WORDS = 4,
    parameter int LEN_HOLD     = 5,
    parameter int TIMEOUT      = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_start,
    input  logic [D_WIDTH-1:0] cmd_len,
    input  logic [D_WIDTH-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [D_WIDTH-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [3:0]         core_control,
    output logic [7:0]         core_add,
    output logic [D_WIDTH-1:0] core_data_in,
    input  logic [D_WIDTH-1:0] core_data_out,
    input  logic               core_end_op
);

    localparam logic [3:0] CMD_IDLE  = 4'b0100;
    localparam logic [3:0] CMD_LEN   = 4'b0101;
    localparam logic [3:0] CMD_DATA  = 4'b0110;
    localparam logic [3:0] CMD_START = 4'b0111;

    localparam int         SH       = $clog2(D_WIDTH);
    localparam logic [7:0] LAST_I   = 8'(N_WORDS - 1);
    localparam logic [7:0] LAST_J   = 8'(DIGEST_WORDS - 1);
    localparam logic [7:0] LEN_LAST = 8'(LEN_HOLD - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN,
        ST_LOAD_A,
        ST_LOAD_D,
        ST_START,
        ST_WAIT,
        ST_RD_A,
        ST_RD_D,
        ST_OUT
    } state_t;

    state_t             state;
    logic [7:0]         nw;
    logic [7:0]         i_cnt;
    logic [7:0]         j_cnt;
    logic [7:0]         len_cnt;
    logic               wait_first;

    logic [D_WIDTH-1:0] words_ceil;
    logic [7:0]         nw_in;
    logic [7:0]         next_i;
    logic               load_stream;

`ifdef SHA3_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic          err_q;
    logic [TW-1:0] wcnt;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Word count for the message: ceil(len / D_WIDTH), clamped to the state size.
    // next_i is the index about to be loaded: 0 when leaving LEN, i+1 otherwise.
    always_comb begin
        words_ceil  = (cmd_len >> SH) + D_WIDTH'(|cmd_len[SH-1:0]);
        nw_in       = (words_ceil > D_WIDTH'(N_WORDS)) ? 8'(N_WORDS) : words_ceil[7:0];
        next_i      = (state == ST_LEN) ? 8'd0 : i_cnt + 8'd1;
        load_stream = (next_i < nw);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            nw           <= '0;
            i_cnt        <= '0;
            j_cnt        <= '0;
            len_cnt      <= '0;
            wait_first   <= 1'b0;
            core_control <= CMD_IDLE;
            core_add     <= '0;
            core_data_in <= '0;
            s_ready      <= 1'b0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_data       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef SHA3_CTRL_TIMEOUT_EN
            err_q        <= 1'b0;
            wcnt         <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        nw           <= nw_in;
                        len_cnt      <= '0;
                        core_control <= CMD_LEN;
                        core_add     <= '0;
                        core_data_in <= cmd_len >> 3;
                        busy         <= 1'b1;
                        state        <= ST_LEN;
`ifdef SHA3_CTRL_TIMEOUT_EN
                        err_q        <= 1'b0;
`endif
                    end
                end
                ST_LEN, ST_LOAD_D: begin
                    if (state == ST_LEN && len_cnt != LEN_LAST) begin
                        len_cnt <= len_cnt + 8'd1;
                    end else if (state == ST_LOAD_D && i_cnt == LAST_I) begin
                        core_control <= CMD_START;
                        core_add     <= '0;
                        core_data_in <= '0;
                        state        <= ST_START;
                    end else begin
                        // Streamed words first park the core on IDLE with s_ready up;
                        // padding words go straight to LOAD_DATA with zero data.
                        i_cnt        <= next_i;
                        core_add     <= next_i;
                        core_data_in <= '0;
                        s_ready      <= load_stream;
                        core_control <= load_stream ? CMD_IDLE : CMD_DATA;
                        state        <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    // With s_ready up this is the stall; after the handshake the
                    // state stays one more cycle so the word is driven twice.
                    if (s_ready) begin
                        if (s_valid) begin
                            s_ready      <= 1'b0;
                            core_data_in <= s_data;
                            core_control <= CMD_DATA;
                        end
                    end else begin
                        state <= ST_LOAD_D;
                    end
                end
                ST_START: begin
                    core_control <= CMD_IDLE;
                    wait_first   <= 1'b1;
                    state        <= ST_WAIT;
`ifdef SHA3_CTRL_TIMEOUT_EN
                    wcnt         <= '0;
`endif
                end
                ST_WAIT: begin
                    // end_op may still be high from the previous hash during the
                    // first cycle after START, so that sample is discarded.
                    wait_first <= 1'b0;
                    if (!wait_first && core_end_op) begin
                        j_cnt    <= '0;
                        core_add <= '0;
                        state    <= ST_RD_A;
                    end
`ifdef SHA3_CTRL_TIMEOUT_EN
                    else if (wcnt == TW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
`endif
                end
                ST_RD_A: begin
                    state <= ST_RD_D;
                end
                ST_RD_D: begin
                    m_data  <= core_data_out;
                    m_valid <= 1'b1;
                    m_last  <= (j_cnt == LAST_J);
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (m_last) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            core_add <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            j_cnt    <= j_cnt + 8'd1;
                            core_add <= j_cnt + 8'd1;
                            state    <= ST_RD_A;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_host_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sha3_host_ctrl with a behavioural sha3_xl core model.
// Latency: n/a (testbench).
// Backpressure: stream source and digest sink randomly gap valid/ready.
module tb_sha3_host_ctrl;
    localparam int DW  = 64;
    localparam int NW  = 25;
    localparam int DGW = 4;
    localparam int LH  = 5;
    localparam int TO  = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start;
    logic [DW-1:0] cmd_len;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;
    logic [3:0]    core_control;
    logic [7:0]    core_add;
    logic [DW-1:0] core_data_in;
    logic [DW-1:0] core_data_out = '0;
    logic          core_end_op   = 1'b0;

    sha3_host_ctrl #(
        .D_WIDTH(DW), .N_WORDS(NW), .DIGEST_WORDS(DGW), .LEN_HOLD(LH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_len(cmd_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .err(err),
        .core_control(core_control), .core_add(core_add),
        .core_data_in(core_data_in), .core_data_out(core_data_out),
        .core_end_op(core_end_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [7:0]  add;
        logic [63:0] dat;
    } cmd_t;

    cmd_t        cmd_q[$];
    cmd_t        exp_q[$];
    logic [1:0]  exp_m[$];   // bit1: compare add, bit0: compare data
    logic [64:0] out_q[$];
    int          hs_cnt, done_cnt, bad_rdy, stab_bad, mvalid_seen, exp_nw;
    bit          phase, prev_hold, stream_to, sink_to;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [63:0] words[NW];
    logic [63:0] dig[DGW];
    int          endop_delay = 30;
    bit          endop_en = 1'b1;
    int          eo_cnt = -1;
    int          checks = 0;
    int          failures = 0;

    // Passive monitor: command trace during the load phase, handshakes, output words.
    always @(negedge clk) begin
        if (!rst) begin
            phase     = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (core_control == 4'b0101) phase = 1'b1;
            if (phase && core_control != 4'b0100) cmd_q.push_back({core_control, core_add, core_data_in});
            if (phase && core_control == 4'b0100 && !s_ready) bad_rdy++;
            if (s_ready && (!phase || core_control != 4'b0100)) bad_rdy++;
            if (core_control == 4'b0111) phase = 1'b0;
            if (s_valid && s_ready) hs_cnt++;
            if (prev_hold && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last)) stab_bad++;
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (m_valid) mvalid_seen++;
            if (m_valid && m_ready) out_q.push_back({m_last, m_data});
            if (done) done_cnt++;
        end
    end

    // sha3_xl model: data_out follows add one cycle later; end_op rises a set delay after START.
    always begin : core_model
        logic [63:0] nd;
        logic [3:0]  cs;
        @(negedge clk);
        nd = (core_add < 8'(DGW)) ? dig[core_add[1:0]] : 64'h0;
        cs = core_control;
        @(posedge clk);
        #1;
        core_data_out = nd;
        if (!rst) begin
            core_end_op = 1'b0;
            eo_cnt      = -1;
        end else if (cs == 4'b0111) begin
            core_end_op = 1'b0;
            eo_cnt      = endop_en ? endop_delay : -1;
        end else if (eo_cnt > 0) begin
            eo_cnt--;
        end
        if (eo_cnt == 0) core_end_op = 1'b1;
    end

    function automatic int first_bad();
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k >= cmd_q.size()) return k;
            if (cmd_q[k].ctl !== exp_q[k].ctl) return k;
            if (exp_m[k][1] && cmd_q[k].add !== exp_q[k].add) return k;
            if (exp_m[k][0] && cmd_q[k].dat !== exp_q[k].dat) return k;
        end
        if (cmd_q.size() != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    function automatic int out_bad();
        if (out_q.size() != DGW) return 100 + out_q.size();
        for (int k = 0; k < DGW; k++)
            if (out_q[k] !== {(k == DGW - 1), dig[k]}) return k;
        return -1;
    endfunction

    task automatic clear_logs();
        cmd_q.delete();
        out_q.delete();
        hs_cnt = 0; done_cnt = 0; bad_rdy = 0; stab_bad = 0; mvalid_seen = 0;
        stream_to = 1'b0; sink_to = 1'b0;
    endtask

    task automatic pulse_start(input logic [63:0] len);
        @(posedge clk); #1;
        cmd_start = 1'b1;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic drive_stream(input int n, input int gap);
        bit got;
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            s_valid = 1'b1;
            s_data  = words[k];
            got = 1'b0;
            for (int t = 0; t < 3000 && !got; t++) begin
                @(negedge clk);
                if (s_ready) got = 1'b1;
                @(posedge clk); #1;
            end
            s_valid = 1'b0;
            if (!got) begin stream_to = 1'b1; return; end
        end
    endtask

    task automatic drive_sink(input int stall_idx, input bit rnd);
        bit got;
        int hold;
        for (int k = 0; k < DGW; k++) begin
            m_ready = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 5000 && !got; t++) begin
                @(negedge clk);
                if (m_valid) got = 1'b1;
            end
            if (!got) begin sink_to = 1'b1; return; end
            hold = (k == stall_idx) ? 10 : (rnd ? $urandom_range(0, 2) : 0);
            repeat (hold) @(negedge clk);
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0;
        end
    endtask

    // Builds the expected command trace from the length and words, then runs one hash.
    task automatic run_op(input logic [63:0] len, input int gap, input int stall_idx,
                          input bit rnd, input bit keep, input bit poke);
        longint unsigned q;
        if (!keep) begin
            for (int k = 0; k < NW; k++) words[k] = {$urandom, $urandom};
            for (int k = 0; k < DGW; k++) dig[k] = {$urandom, $urandom};
        end
        q = len / 64 + (((len % 64) != 0) ? 1 : 0);
        exp_nw = (q > NW) ? NW : int'(q);
        exp_q.delete();
        exp_m.delete();
        for (int k = 0; k < LH; k++) begin
            exp_q.push_back({4'b0101, 8'h00, len >> 3});
            exp_m.push_back(2'b01);
        end
        for (int i = 0; i < NW; i++)
            for (int r = 0; r < 2; r++) begin
                exp_q.push_back({4'b0110, 8'(i), (i < exp_nw) ? words[i] : 64'h0});
                exp_m.push_back(2'b11);
            end
        exp_q.push_back({4'b0111, 8'h00, 64'h0});
        exp_m.push_back(2'b00);
        @(posedge clk); #1;
        clear_logs();
        pulse_start(len);
        fork
            drive_stream(exp_nw, gap);
            drive_sink(stall_idx, rnd);
            begin
                if (poke) begin
                    repeat (20) @(posedge clk);
                    #1;
                    cmd_start = 1'b1;
                    cmd_len   = ~len;
                    @(posedge clk); #1;
                    cmd_start = 1'b0;
                end
            end
        join
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (core_control !== 4'b0100) begin
            failures++; $display("FAIL reset_control: got %b need 0100", core_control);
        end
        checks++;
        if ({core_add, core_data_in, m_data} !== '0) begin
            failures++; $display("FAIL reset_data: got add=%h din=%h mdata=%h need 0", core_add, core_data_in, m_data);
        end
        checks++;
        if ({s_ready, m_valid, m_last, busy, done, err} !== 6'b0) begin
            failures++; $display("FAIL reset_flags: got %b need 000000", {s_ready, m_valid, m_last, busy, done, err});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle_busy: got %b need 0", busy);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < NW; k++) words[k] = {$urandom, $urandom};
        words[0] = 64'hb2cfa3f83ffa53af;
        dig[0] = 64'h0123456789abcdef; dig[1] = 64'hfedcba9876543210;
        dig[2] = 64'h5a5a5a5aa5a5a5a5; dig[3] = 64'hdeadbeefcafef00d;
        endop_delay = 30;
        run_op(64'd64, 0, -1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (first_bad() != -1) begin
            failures++; $display("FAIL basic_cmd_seq: first bad entry %0d of %0d seen, need none of %0d", first_bad(), cmd_q.size(), exp_q.size());
        end
        checks++;
        if (hs_cnt != 1) begin
            failures++; $display("FAIL basic_handshakes: got %0d need 1", hs_cnt);
        end
        checks++;
        if (out_bad() != -1 || sink_to) begin
            failures++; $display("FAIL basic_digest: bad index/code %0d timeout %0d, need -1", out_bad(), sink_to);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++; $display("FAIL basic_done: got %0d pulses need 1", done_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL basic_busy_after: got %b need 0", busy);
        end
    endtask

    task automatic test_gapped();
        endop_delay = 30;
        run_op(64'd200, 3, -1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (hs_cnt != 4 || stream_to) begin
            failures++; $display("FAIL gapped_handshakes: got %0d (timeout %0d) need 4", hs_cnt, stream_to);
        end
        checks++;
        if (bad_rdy != 0) begin
            failures++; $display("FAIL gapped_stall: got %0d bad s_ready cycles need 0", bad_rdy);
        end
        checks++;
        if (first_bad() != -1) begin
            failures++; $display("FAIL gapped_cmd_seq: first bad entry %0d, need none", first_bad());
        end
        checks++;
        if (out_bad() != -1) begin
            failures++; $display("FAIL gapped_digest: bad index/code %0d need -1", out_bad());
        end
    endtask

    task automatic test_backpressure();
        endop_delay = 12;
        run_op(64'd512, 0, 1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stab_bad != 0) begin
            failures++; $display("FAIL bp_stable: got %0d changes under stall need 0", stab_bad);
        end
        checks++;
        if (mvalid_seen != 14) begin
            failures++; $display("FAIL bp_valid_cycles: got %0d need 14", mvalid_seen);
        end
        checks++;
        if (out_bad() != -1) begin
            failures++; $display("FAIL bp_digest: bad index/code %0d need -1", out_bad());
        end
        checks++;
        if (done_cnt != 1) begin
            failures++; $display("FAIL bp_done: got %0d need 1", done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        endop_delay = 20;
        run_op(64'd300, 1, -1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (first_bad() != -1) begin
            failures++; $display("FAIL ignore_cmd_seq: first bad entry %0d, need none", first_bad());
        end
        checks++;
        if (done_cnt != 1 || out_bad() != -1) begin
            failures++; $display("FAIL ignore_digest: done %0d code %0d, need 1 and -1", done_cnt, out_bad());
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || core_control !== 4'b0100) begin
            failures++; $display("FAIL ignore_idle: busy %b ctl %b, need 0 and 0100", busy, core_control);
        end
    endtask

    task automatic test_random();
        logic [63:0] len;
        for (int it = 0; it < 8; it++) begin
            case (it)
                0: len = 64'd0;
                1: len = 64'd1;
                2: len = 64'd1600;
                3: len = 64'd1601;
                4: len = 64'hffff_ffff_ffff_ffff;
                default: len = 64'($urandom_range(1, 2000));
            endcase
            endop_delay = $urandom_range(1, 40);
            run_op(len, $urandom_range(0, 3), -1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (first_bad() != -1) begin
                failures++; $display("FAIL rand_cmd_seq len=%0d: first bad entry %0d, need none", len, first_bad());
            end
            checks++;
            if (hs_cnt != exp_nw || bad_rdy != 0) begin
                failures++; $display("FAIL rand_stream len=%0d: got %0d hs %0d bad, need %0d hs 0 bad", len, hs_cnt, bad_rdy, exp_nw);
            end
            checks++;
            if (out_bad() != -1 || done_cnt != 1 || stab_bad != 0) begin
                failures++; $display("FAIL rand_digest len=%0d: code %0d done %0d unstable %0d, need -1 1 0", len, out_bad(), done_cnt, stab_bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found, prev7;
        clear_logs();
        pulse_start(64'd0);
        found = 1'b0;
        prev7 = 1'b0;
        for (int t = 0; t < 300 && !found; t++) begin
            @(negedge clk);
            if (core_control == 4'b0110 && core_add == 8'd7) begin
                if (prev7) found = 1'b1;
                prev7 = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL rstmid_reach: LOAD_D i=7 reached %0d need 1", found);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({core_control, core_add, core_data_in, s_ready, m_valid, m_last, m_data, busy, done, err}
            !== {4'b0100, 8'h0, 64'h0, 3'b0, 64'h0, 3'b0}) begin
            failures++; $display("FAIL rstmid_outputs: ctl %b add %h din %h flags %b mdata %h, need 0100 and zeros",
                core_control, core_add, core_data_in, {s_ready, m_valid, m_last, busy, done, err}, m_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        checks++;
        if (mvalid_seen != 0 || done_cnt != 0) begin
            failures++; $display("FAIL rstmid_no_output: valid %0d done %0d, need 0 0", mvalid_seen, done_cnt);
        end
        repeat (2) @(negedge clk);
        endop_delay = 30;
        run_op(64'd200, 1, -1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (first_bad() != -1 || hs_cnt != 4) begin
            failures++; $display("FAIL rstmid_rerun_seq: first bad %0d hs %0d, need -1 and 4", first_bad(), hs_cnt);
        end
        checks++;
        if (out_bad() != -1 || done_cnt != 1) begin
            failures++; $display("FAIL rstmid_rerun_digest: code %0d done %0d, need -1 1", out_bad(), done_cnt);
        end
    endtask

    task automatic test_no_endop();
        int cyc;
        endop_en = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        pulse_start(64'd0);
`ifdef SHA3_CTRL_TIMEOUT_EN
        cyc = 0;
        while (busy && cyc < TO + 500) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || cyc < TO) begin
            failures++; $display("FAIL timeout_err: busy %b err %b after %0d cycles, need 0 1 and >= %0d", busy, err, cyc, TO);
        end
        checks++;
        if (mvalid_seen != 0 || done_cnt != 0 || core_control !== 4'b0100) begin
            failures++; $display("FAIL timeout_quiet: valid %0d done %0d ctl %b, need 0 0 0100", mvalid_seen, done_cnt, core_control);
        end
        endop_en = 1'b1;
        endop_delay = 10;
        run_op(64'd64, 0, -1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0 || out_bad() != -1) begin
            failures++; $display("FAIL timeout_recover: err %b code %0d, need 0 -1", err, out_bad());
        end
`else
        cyc = 0;
        repeat (400) begin
            @(negedge clk);
            if (err !== 1'b0) cyc++;
        end
        checks++;
        if (busy !== 1'b1 || cyc != 0) begin
            failures++; $display("FAIL noendop_wait: busy %b err cycles %0d, need 1 0", busy, cyc);
        end
        checks++;
        if (mvalid_seen != 0 || done_cnt != 0) begin
            failures++; $display("FAIL noendop_quiet: valid %0d done %0d, need 0 0", mvalid_seen, done_cnt);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        endop_en = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL noendop_reset: busy %b need 0", busy);
        end
`endif
    endtask

    initial begin
        rst = 1'b0; cmd_start = 1'b0; cmd_len = '0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
        for (int k = 0; k < DGW; k++) dig[k] = '0;
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_start_ignored();
        test_random();
        test_reset_mid();
        test_no_endop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
